// File: rtl/nav_pkg.sv
// Shared definitions for the navigation controller.
//   state_t : controller state (IDLE, MOVING)
//   OP_*    : command opcodes carried in cmd[7:6]; any opcode with bit 7
//             set is ignored by the controller.
package nav_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    MOVING = 1'b1
  } state_t;

  localparam logic [1:0] OP_STOP = 2'b00;
  localparam logic [1:0] OP_GO   = 2'b01;

endpackage : nav_pkg

// File: rtl/buzz_gen.sv
// Piezo buzzer driver for the blocked-in-transit condition.
// While en is high a counter runs 0..BUZZ_HALF-1 and the tone flop toggles
// at every wrap, giving a square wave with a half-period of BUZZ_HALF clks.
// When en is low the counter and tone flop clear, and both drive outputs
// are held low so the piezo sees no DC bias.
// Ports:
//   clk    : system clock
//   rst    : asynchronous active-high reset
//   en     : buzzer enable
//   buzz   : tone output
//   buzz_n : complement of buzz while enabled, 0 otherwise
module buzz_gen #(
  parameter int BUZZ_HALF = 12500
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic buzz,
  output logic buzz_n
);

  localparam int CNT_W = (BUZZ_HALF > 1) ? $clog2(BUZZ_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUZZ_HALF - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tone_q, tone_d;

  always_comb begin
    cnt_d  = '0;
    tone_d = 1'b0;
    if (en) begin
      // Explicit wrap at BUZZ_HALF-1 keeps the counter from running past
      // the half-period when BUZZ_HALF is not a power of two.
      if (cnt_q == CNT_MAX) begin
        cnt_d  = '0;
        tone_d = ~tone_q;
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
        tone_d = tone_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

  // Gating with en makes both outputs drop in the same cycle the enable
  // falls, rather than one cycle later when the flops clear.
  assign buzz   = en &  tone_q;
  assign buzz_n = en & ~tone_q;

endmodule : buzz_gen

// File: rtl/nav_cntrl.sv
// Navigation controller: accepts go/stop commands from the host, watches
// barcode station IDs, and reports when the vehicle is in transit.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   cmd_rdy, cmd      : host command handshake input and byte
//   clr_cmd_rdy       : one-cycle consume pulse for cmd_rdy
//   ID_vld, ID        : barcode station ID handshake input and byte
//   clr_ID_vld        : one-cycle consume pulse for ID_vld
//   OK2Move           : path clear, asynchronous to clk
//   in_transit        : high while a go command is active
//   go                : in_transit gated by synchronized OK2Move
//   buzz, buzz_n      : complementary piezo drive when blocked in transit
module nav_cntrl
  import nav_pkg::*;
#(
  parameter int BUZZ_HALF = 12500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_rdy,
  input  logic [7:0] cmd,
  output logic       clr_cmd_rdy,
  input  logic       ID_vld,
  input  logic [7:0] ID,
  output logic       clr_ID_vld,
  input  logic       OK2Move,
  output logic       in_transit,
  output logic       go,
  output logic       buzz,
  output logic       buzz_n
);

  state_t     state_q, state_d;
  logic [5:0] dest_q, dest_d;
  logic       ok_meta_q, ok_sync_q;
  logic       buzz_en;
  logic       unused_id_bits;

  // Station ID bits [7:6] carry no meaning for routing.
  assign unused_id_bits = ^ID[7:6];

  // Two-flop synchronizer for the asynchronous obstacle sensor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ok_meta_q <= 1'b0;
      ok_sync_q <= 1'b0;
    end else begin
      ok_meta_q <= OK2Move;
      ok_sync_q <= ok_meta_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
    end
  end

  // Commands take priority over IDs. A pending ID is left untouched in a
  // command cycle and is therefore judged next cycle against the new state
  // and destination.
  always_comb begin
    state_d     = state_q;
    dest_d      = dest_q;
    clr_cmd_rdy = 1'b0;
    clr_ID_vld  = 1'b0;
    if (cmd_rdy) begin
      clr_cmd_rdy = 1'b1;
      case (cmd[7:6])
        OP_GO: begin
          dest_d  = cmd[5:0];
          state_d = MOVING;
        end
        OP_STOP: state_d = IDLE;
        default: ;
      endcase
    end else if (ID_vld) begin
      clr_ID_vld = 1'b1;
      if ((state_q == MOVING) && (ID[5:0] == dest_q)) begin
        state_d = IDLE;
      end
    end
  end

  assign in_transit = (state_q == MOVING);
  assign go         = in_transit & ok_sync_q;
  assign buzz_en    = in_transit & ~ok_sync_q;

  buzz_gen #(
    .BUZZ_HALF(BUZZ_HALF)
  ) u_buzz_gen (
    .clk   (clk),
    .rst   (rst),
    .en    (buzz_en),
    .buzz  (buzz),
    .buzz_n(buzz_n)
  );

endmodule : nav_cntrl

// File: tb/tb_nav_cntrl.sv
module tb_nav_cntrl;

  localparam int BH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_rdy = 1'b0;
  logic [7:0] cmd = 8'h00;
  logic       clr_cmd_rdy;
  logic       ID_vld = 1'b0;
  logic [7:0] ID = 8'h00;
  logic       clr_ID_vld;
  logic       OK2Move = 1'b1;
  logic       in_transit, go, buzz, buzz_n;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the controller
  bit       m_moving;
  bit [5:0] m_dest;
  bit       m_ok_hist [2];   // raw OK2Move seen one and two edges ago
  int       m_blocked_cycles;

  nav_cntrl #(.BUZZ_HALF(BH)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_rdy    (cmd_rdy),
    .cmd        (cmd),
    .clr_cmd_rdy(clr_cmd_rdy),
    .ID_vld     (ID_vld),
    .ID         (ID),
    .clr_ID_vld (clr_ID_vld),
    .OK2Move    (OK2Move),
    .in_transit (in_transit),
    .go         (go),
    .buzz       (buzz),
    .buzz_n     (buzz_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_moving         = 0;
    m_dest           = '0;
    m_ok_hist[0]     = 0;
    m_ok_hist[1]     = 0;
    m_blocked_cycles = 0;
  endtask

  // One clock cycle: called just after a negedge with inputs set. Checks all
  // outputs against the model, clocks, updates the model, then emulates the
  // request sources dropping their flags after a consume pulse.
  task automatic cycle(input string tag);
    bit e_clr_cmd, e_clr_id, e_blocked, e_buzz;
    #1;
    e_clr_cmd = cmd_rdy;
    e_clr_id  = ID_vld && !cmd_rdy;
    e_blocked = m_moving && !m_ok_hist[1];
    e_buzz    = e_blocked && (((m_blocked_cycles / BH) % 2) == 1);
    chk({tag, ".clr_cmd_rdy"}, clr_cmd_rdy, e_clr_cmd);
    chk({tag, ".clr_ID_vld"},  clr_ID_vld,  e_clr_id);
    chk({tag, ".in_transit"},  in_transit,  m_moving);
    chk({tag, ".go"},          go,          m_moving && m_ok_hist[1]);
    chk({tag, ".buzz"},        buzz,        e_buzz);
    chk({tag, ".buzz_n"},      buzz_n,      e_blocked && !e_buzz);
    @(posedge clk);
    if (cmd_rdy) begin
      if (cmd[7:6] == 2'b01) begin
        m_moving = 1;
        m_dest   = cmd[5:0];
      end else if (cmd[7:6] == 2'b00) begin
        m_moving = 0;
      end
    end else if (ID_vld && m_moving && (ID[5:0] == m_dest)) begin
      m_moving = 0;
    end
    m_blocked_cycles = e_blocked ? m_blocked_cycles + 1 : 0;
    m_ok_hist[1] = m_ok_hist[0];
    m_ok_hist[0] = OK2Move;
    @(negedge clk);
    if (e_clr_cmd) cmd_rdy = 1'b0;
    if (e_clr_id)  ID_vld  = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    cmd = c;
    cmd_rdy = 1'b1;
  endtask

  task automatic send_id(input logic [7:0] i);
    ID = i;
    ID_vld = 1'b1;
  endtask

  initial begin
    model_reset();
    // Reset state
    @(negedge clk);
    #1;
    chk("reset.in_transit", in_transit, 1'b0);
    chk("reset.go", go, 1'b0);
    chk("reset.buzz", buzz, 1'b0);
    chk("reset.buzz_n", buzz_n, 1'b0);
    chk("reset.clr_cmd_rdy", clr_cmd_rdy, 1'b0);
    chk("reset.clr_ID_vld", clr_ID_vld, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    cycle("idle0");
    cycle("idle1");
    cycle("idle2");

    // Accept and arrive
    send_cmd(8'h45); cycle("accept");
    cycle("accept_next");
    send_id(8'h05);  cycle("arrive");
    cycle("arrive_next");

    // ID discarded in IDLE; ignored opcode in IDLE
    send_id(8'hC5);  cycle("idle_id");
    send_cmd(8'hC5); cycle("idle_op1x");
    cycle("idle_op1x_next");

    // Wrong station
    send_cmd(8'h45); cycle("go5");
    send_id(8'h03);  cycle("wrong_id");
    cycle("wrong_id_next");

    // Redirect, old destination ignored, new one stops
    send_cmd(8'h4A); cycle("redirect");
    send_id(8'h05);  cycle("old_dest");
    cycle("old_dest_next");
    send_id(8'h8A);  cycle("new_dest");
    cycle("new_dest_next");

    // Stop mid-transit; ignored opcode mid-transit
    send_cmd(8'h45); cycle("go5b");
    send_cmd(8'hC0); cycle("moving_op1x");
    send_cmd(8'h00); cycle("stop");
    cycle("stop_next");

    // Simultaneous command and ID
    send_cmd(8'h47);
    send_id(8'h07);  cycle("simul_c1");
    cycle("simul_c2");
    cycle("simul_c3");

    // Obstacle and buzzer
    send_cmd(8'h45); cycle("obst_go");
    for (int i = 0; i < 3; i++) cycle("obst_clear");
    OK2Move = 1'b0;
    for (int i = 0; i < 22; i++) cycle("obst_blocked");
    OK2Move = 1'b1;
    for (int i = 0; i < 4; i++) cycle("obst_cleared");

    // Reset mid-transit, asynchronous effect
    OK2Move = 1'b0;
    for (int i = 0; i < 8; i++) cycle("pre_rst");
    #2 rst = 1'b1;
    #1;
    chk("async_rst.in_transit", in_transit, 1'b0);
    chk("async_rst.go", go, 1'b0);
    chk("async_rst.buzz", buzz, 1'b0);
    chk("async_rst.buzz_n", buzz_n, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    OK2Move = 1'b1;
    send_id(8'h05);  cycle("post_rst_id");
    cycle("post_rst_idle");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      if (!cmd_rdy && ($urandom_range(0, 3) == 0)) begin
        cmd = {2'($urandom_range(0, 3)), 6'($urandom_range(0, 7))};
        cmd_rdy = 1'b1;
      end
      if (!ID_vld && ($urandom_range(0, 2) == 0)) begin
        ID = {2'($urandom), 6'($urandom_range(0, 7))};
        ID_vld = 1'b1;
      end
      if ($urandom_range(0, 9) == 0) OK2Move = ~OK2Move;
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_nav_cntrl
